// File: rtl/pipeline_control_unit_pkg.sv
// Shared definitions for the pipeline control unit.
// Holds the controller state encoding and the NOP instruction word that the
// IF/ID register loads when it is flushed.
package pipeline_control_unit_pkg;

    // RUN: normal arbitration. MEM_WAIT: frozen behind a busy data memory.
    // REDIRECT_PEND: frozen, with a taken-branch target waiting to be applied.
    typedef enum logic [1:0] {
        RUN           = 2'd0,
        MEM_WAIT      = 2'd1,
        REDIRECT_PEND = 2'd2
    } pcu_state_e;

    // addi x0, x0, 0 -- canonical RISC-V NOP used by the IF/ID flush
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipeline_control_unit_if.sv
// Bundle of request and control signals between the pipeline and its
// control unit.
//   master: the pipeline side, drives stall/branch/memory requests and
//           receives the per-stage controls and performance counters.
//   slave : the control unit, consumes the requests and drives the controls.
interface pipeline_control_unit_if #(
    parameter int XLEN      = 32,
    parameter int CNT_WIDTH = 16
);
    logic                 stall_req;
    logic                 branch_taken;
    logic [XLEN-1:0]      branch_target;
    logic                 dmem_busy;

    logic                 pc_write;
    logic                 pc_redirect;
    logic [XLEN-1:0]      redirect_target;
    logic                 if_id_write;
    logic                 if_id_flush;
    logic                 id_ex_bubble;
    logic                 pipe_hold;
    logic                 mem_wb_bubble;
    logic [CNT_WIDTH-1:0] stall_cycles;
    logic [CNT_WIDTH-1:0] flush_count;
    logic [CNT_WIDTH-1:0] mem_wait_cycles;
    logic                 stall_timeout;

    modport master (
        output stall_req, branch_taken, branch_target, dmem_busy,
        input  pc_write, pc_redirect, redirect_target, if_id_write,
               if_id_flush, id_ex_bubble, pipe_hold, mem_wb_bubble,
               stall_cycles, flush_count, mem_wait_cycles, stall_timeout
    );

    modport slave (
        input  stall_req, branch_taken, branch_target, dmem_busy,
        output pc_write, pc_redirect, redirect_target, if_id_write,
               if_id_flush, id_ex_bubble, pipe_hold, mem_wb_bubble,
               stall_cycles, flush_count, mem_wait_cycles, stall_timeout
    );
endinterface

// File: rtl/pipeline_control_unit_sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
// Ports:
//   clk   - core clock, rising edge
//   reset - asynchronous, active-high; clears the count
//   inc   - count one event this cycle
//   count - current value; sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Increment only while below all-ones so the counter never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_control_unit.sv
// Pipeline control unit for the 5-stage core.
// Arbitrates data-memory wait, taken-branch flush and load-use stall into
// per-stage enable/flush/bubble controls. A redirect that arrives while memory
// is busy is parked and applied once memory releases. Also keeps saturating
// performance counters and a sticky load-use stall watchdog.
// Ports:
//   clk   - core clock, rising edge
//   reset - asynchronous, active-high
//   bus   - pipeline_control_unit_if.slave: requests in, controls/counters out
module pipeline_control_unit
    import pipeline_control_unit_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int CNT_WIDTH = 16,
    parameter int MAX_STALL = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    pipeline_control_unit_if.slave  bus
);

    localparam int WD_W = $clog2(MAX_STALL + 1);

    pcu_state_e      state;
    pcu_state_e      next_state;
    logic [XLEN-1:0] pend_target;
    logic [WD_W-1:0] wd_count;
    logic            timeout_q;

    logic            run_rules;
    logic            latch_en;
    logic            stall_inc;
    logic            flush_inc;
    logic            pc_write_c;
    logic            if_id_write_c;
    logic            pc_redirect_c;
    logic [XLEN-1:0] target_c;
    logic            if_id_flush_c;
    logic            id_ex_bubble_c;
    logic            pipe_hold_c;
    logic            mem_wb_bubble_c;

    // State register, parked redirect target, watchdog and sticky timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            pend_target <= '0;
            wd_count    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state <= next_state;
            if (latch_en) begin
                pend_target <= bus.branch_target;
            end
            // Only an unbroken run of acted-on stalls advances the watchdog.
            if (stall_inc) begin
                if (wd_count != WD_W'(MAX_STALL)) begin
                    wd_count <= wd_count + 1'b1;
                end
                if (wd_count >= WD_W'(MAX_STALL - 1)) begin
                    timeout_q <= 1'b1;
                end
            end else begin
                wd_count <= '0;
            end
        end
    end

    // Mealy next-state and control decode. MEM_WAIT falls through to the RUN
    // rules on the cycle memory releases, so nothing is lost to a dead cycle.
    // Reset overrides the controls combinationally so the pipeline is flushed
    // for as long as reset is held.
    always_comb begin
        next_state      = state;
        run_rules       = 1'b0;
        latch_en        = 1'b0;
        stall_inc       = 1'b0;
        flush_inc       = 1'b0;
        pc_write_c      = 1'b0;
        if_id_write_c   = 1'b0;
        pc_redirect_c   = 1'b0;
        target_c        = pend_target;
        if_id_flush_c   = 1'b0;
        id_ex_bubble_c  = 1'b0;
        pipe_hold_c     = 1'b0;
        mem_wb_bubble_c = 1'b0;

        unique case (state)
            RUN: begin
                run_rules = 1'b1;
            end
            MEM_WAIT: begin
                if (bus.dmem_busy) begin
                    pipe_hold_c     = 1'b1;
                    mem_wb_bubble_c = 1'b1;
                    if (bus.branch_taken) begin
                        latch_en   = 1'b1;
                        next_state = REDIRECT_PEND;
                    end
                end else begin
                    run_rules = 1'b1;
                end
            end
            REDIRECT_PEND: begin
                if (bus.dmem_busy) begin
                    pipe_hold_c     = 1'b1;
                    mem_wb_bubble_c = 1'b1;
                end else begin
                    // Parked redirect wins; any stall request is wrong-path.
                    pc_write_c     = 1'b1;
                    pc_redirect_c  = 1'b1;
                    target_c       = pend_target;
                    if_id_flush_c  = 1'b1;
                    id_ex_bubble_c = 1'b1;
                    flush_inc      = 1'b1;
                    next_state     = RUN;
                end
            end
            default: begin
                next_state = RUN;
            end
        endcase

        if (run_rules) begin
            if (bus.dmem_busy) begin
                pipe_hold_c     = 1'b1;
                mem_wb_bubble_c = 1'b1;
                latch_en        = bus.branch_taken;
                next_state      = bus.branch_taken ? REDIRECT_PEND : MEM_WAIT;
            end else if (bus.branch_taken) begin
                pc_write_c     = 1'b1;
                pc_redirect_c  = 1'b1;
                target_c       = bus.branch_target;
                if_id_flush_c  = 1'b1;
                id_ex_bubble_c = 1'b1;
                flush_inc      = 1'b1;
                next_state     = RUN;
            end else if (bus.stall_req) begin
                id_ex_bubble_c = 1'b1;
                stall_inc      = 1'b1;
                next_state     = RUN;
            end else begin
                pc_write_c    = 1'b1;
                if_id_write_c = 1'b1;
                next_state    = RUN;
            end
        end

        if (reset) begin
            pc_write_c      = 1'b0;
            if_id_write_c   = 1'b0;
            pc_redirect_c   = 1'b0;
            if_id_flush_c   = 1'b1;
            id_ex_bubble_c  = 1'b1;
            pipe_hold_c     = 1'b0;
            mem_wb_bubble_c = 1'b1;
        end
    end

    assign bus.pc_write        = pc_write_c;
    assign bus.if_id_write     = if_id_write_c;
    assign bus.pc_redirect     = pc_redirect_c;
    assign bus.redirect_target = target_c;
    assign bus.if_id_flush     = if_id_flush_c;
    assign bus.id_ex_bubble    = id_ex_bubble_c;
    assign bus.pipe_hold       = pipe_hold_c;
    assign bus.mem_wb_bubble   = mem_wb_bubble_c;
    assign bus.stall_timeout   = timeout_q;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (bus.stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (bus.flush_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_mem_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bus.dmem_busy),
        .count (bus.mem_wait_cycles)
    );

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed testbench for pipeline_control_unit. Two instances share the same
// request stimulus: one with 16-bit counters and one with 4-bit counters so
// counter saturation can be observed in a short run.
module tb_pipeline_control_unit;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    pipeline_control_unit_if #(.XLEN(32), .CNT_WIDTH(16)) ifm ();
    pipeline_control_unit_if #(.XLEN(32), .CNT_WIDTH(4))  ifs ();

    assign ifs.stall_req     = ifm.stall_req;
    assign ifs.branch_taken  = ifm.branch_taken;
    assign ifs.branch_target = ifm.branch_target;
    assign ifs.dmem_busy     = ifm.dmem_busy;

    pipeline_control_unit #(.XLEN(32), .CNT_WIDTH(16), .MAX_STALL(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifm)
    );

    pipeline_control_unit #(.XLEN(32), .CNT_WIDTH(4), .MAX_STALL(8)) dut_small (
        .clk   (clk),
        .reset (reset),
        .bus   (ifs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic apply_stimulus(input logic stall, input logic branch,
                                  input logic [31:0] target, input logic busy);
        @(negedge clk);
        ifm.stall_req     = stall;
        ifm.branch_taken  = branch;
        ifm.branch_target = target;
        ifm.dmem_busy     = busy;
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, " pc_write"},      ifm.pc_write,      0);
        check_output({tag, " if_id_write"},   ifm.if_id_write,   0);
        check_output({tag, " pc_redirect"},   ifm.pc_redirect,   0);
        check_output({tag, " if_id_flush"},   ifm.if_id_flush,   1);
        check_output({tag, " id_ex_bubble"},  ifm.id_ex_bubble,  1);
        check_output({tag, " pipe_hold"},     ifm.pipe_hold,     0);
        check_output({tag, " mem_wb_bubble"}, ifm.mem_wb_bubble, 1);
        check_output({tag, " stall_cycles"},  ifm.stall_cycles,  0);
        check_output({tag, " flush_count"},   ifm.flush_count,   0);
        check_output({tag, " mem_wait"},      ifm.mem_wait_cycles, 0);
        check_output({tag, " timeout"},       ifm.stall_timeout, 0);
    endtask

    task automatic check_freeze(input string tag);
        check_output({tag, " pc_write"},      ifm.pc_write,      0);
        check_output({tag, " if_id_write"},   ifm.if_id_write,   0);
        check_output({tag, " pipe_hold"},     ifm.pipe_hold,     1);
        check_output({tag, " mem_wb_bubble"}, ifm.mem_wb_bubble, 1);
        check_output({tag, " pc_redirect"},   ifm.pc_redirect,   0);
    endtask

    task automatic check_run(input string tag);
        check_output({tag, " pc_write"},     ifm.pc_write,     1);
        check_output({tag, " if_id_write"},  ifm.if_id_write,  1);
        check_output({tag, " pc_redirect"},  ifm.pc_redirect,  0);
        check_output({tag, " id_ex_bubble"}, ifm.id_ex_bubble, 0);
        check_output({tag, " pipe_hold"},    ifm.pipe_hold,    0);
    endtask

    task automatic check_redirect(input string tag, input logic [31:0] target);
        check_output({tag, " pc_redirect"},  ifm.pc_redirect,     1);
        check_output({tag, " pc_write"},     ifm.pc_write,        1);
        check_output({tag, " target"},       ifm.redirect_target, target);
        check_output({tag, " if_id_flush"},  ifm.if_id_flush,     1);
        check_output({tag, " id_ex_bubble"}, ifm.id_ex_bubble,    1);
        check_output({tag, " pipe_hold"},    ifm.pipe_hold,       0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        ifm.stall_req     = 1'b0;
        ifm.branch_taken  = 1'b0;
        ifm.branch_target = '0;
        ifm.dmem_busy     = 1'b0;
        #2;
        check_reset_outputs("reset");

        @(negedge clk);
        reset = 1'b0;

        // Idle cycles
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(0, 0, 32'h0, 0);
            check_run("idle");
        end
        check_output("idle stall_cycles", ifm.stall_cycles, 0);
        check_output("idle flush_count",  ifm.flush_count,  0);
        check_output("idle mem_wait",     ifm.mem_wait_cycles, 0);

        // Single load-use stall
        apply_stimulus(1, 0, 32'h0, 0);
        check_output("stall pc_write",     ifm.pc_write,     0);
        check_output("stall if_id_write",  ifm.if_id_write,  0);
        check_output("stall id_ex_bubble", ifm.id_ex_bubble, 1);
        check_output("stall pc_redirect",  ifm.pc_redirect,  0);
        apply_stimulus(0, 0, 32'h0, 0);
        check_run("post stall");
        check_output("post stall stall_cycles", ifm.stall_cycles, 1);

        // Branch beats a simultaneous stall
        apply_stimulus(1, 1, 32'h0000_0040, 0);
        check_redirect("branch+stall", 32'h0000_0040);
        apply_stimulus(0, 0, 32'h0, 0);
        check_run("post branch");
        check_output("post branch stall_cycles", ifm.stall_cycles, 1);
        check_output("post branch flush_count",  ifm.flush_count,  1);

        // Memory wait with a branch in the second busy cycle
        apply_stimulus(0, 0, 32'h0, 1);
        check_freeze("busy1");
        apply_stimulus(0, 1, 32'h0000_0100, 1);
        check_freeze("busy2 branch");
        apply_stimulus(0, 0, 32'h0000_DEAD, 1);
        check_freeze("busy3");
        apply_stimulus(1, 0, 32'h0000_DEAD, 0);
        check_redirect("pending release", 32'h0000_0100);
        apply_stimulus(0, 0, 32'h0, 0);
        check_run("after pending");
        check_output("after pending mem_wait",     ifm.mem_wait_cycles, 3);
        check_output("after pending flush_count",  ifm.flush_count,     2);
        check_output("after pending stall_cycles", ifm.stall_cycles,    1);

        // Busy falls together with a fresh branch: RUN rules pass it through
        apply_stimulus(0, 0, 32'h0, 1);
        check_freeze("busy single");
        apply_stimulus(0, 1, 32'h0000_0200, 0);
        check_redirect("release branch", 32'h0000_0200);
        apply_stimulus(0, 0, 32'h0, 0);
        check_run("after release branch");
        check_output("release flush_count", ifm.flush_count,     3);
        check_output("release mem_wait",    ifm.mem_wait_cycles, 4);

        // Broken stall runs must not trip the watchdog
        for (int i = 0; i < 4; i++) apply_stimulus(1, 0, 32'h0, 0);
        apply_stimulus(0, 0, 32'h0, 0);
        for (int i = 0; i < 4; i++) apply_stimulus(1, 0, 32'h0, 0);
        apply_stimulus(0, 0, 32'h0, 0);
        check_output("split timeout",      ifm.stall_timeout, 0);
        check_output("split stall_cycles", ifm.stall_cycles,  9);
        check_output("split small stall",  ifs.stall_cycles,  9);

        // Eight consecutive stalls set the watchdog
        for (int i = 0; i < 7; i++) apply_stimulus(1, 0, 32'h0, 0);
        apply_stimulus(1, 0, 32'h0, 0);
        check_output("wd 7 cycles timeout", ifm.stall_timeout, 0);
        apply_stimulus(0, 0, 32'h0, 0);
        check_output("wd 8 cycles timeout", ifm.stall_timeout, 1);
        apply_stimulus(0, 0, 32'h0, 0);
        check_output("wd sticky timeout",   ifm.stall_timeout, 1);
        check_output("wd stall_cycles",     ifm.stall_cycles,  17);
        check_output("wd small saturate",   ifs.stall_cycles,  15);

        for (int i = 0; i < 4; i++) apply_stimulus(1, 0, 32'h0, 0);
        apply_stimulus(0, 0, 32'h0, 0);
        check_output("more stall_cycles",  ifm.stall_cycles, 21);
        check_output("more small stall",   ifs.stall_cycles, 15);
        check_output("small flush_count",  ifs.flush_count,  3);
        check_output("small mem_wait",     ifs.mem_wait_cycles, 4);

        // Reset while a redirect is parked behind a busy memory
        apply_stimulus(0, 1, 32'h0000_0300, 1);
        check_freeze("pre-reset branch");
        apply_stimulus(0, 0, 32'h0, 1);
        check_freeze("pre-reset wait");
        reset = 1'b1;
        #1;
        check_reset_outputs("mid reset");
        @(negedge clk);
        reset = 1'b0;
        ifm.dmem_busy = 1'b0;
        #1;
        check_run("after reset");
        apply_stimulus(0, 0, 32'h0, 0);
        check_run("after reset 2");
        check_output("after reset flush_count", ifm.flush_count, 0);
        check_output("after reset timeout",     ifm.stall_timeout, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
